// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter and its helpers.
//   ST_IDLE / ST_BUSY : state encoding of the grant FSM
//   state_t           : enum built on that encoding
//   clog2()           : ceiling log2, usable in constant expressions
//   tag_width()       : source-tag width for a requester count (minimum 1)
package fifo_wr_arbiter_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // A single requester still needs a one-bit tag on the FIFO word.
  function automatic int tag_width(input int num_req);
    return (clog2(num_req) < 1) ? 1 : clog2(num_req);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of the requester streams, the FIFO write port and the status flags
// around fifo_wr_arbiter.
//   i_req_valid/i_req_data/i_req_last : requester beats (k at [k*DATA_WIDTH +: DATA_WIDTH])
//   o_req_ready                       : per-requester accept
//   o_fifo_wen/o_fifo_wdata           : FIFO write, word = {grant_id, payload}
//   i_fifo_wfull                      : FIFO full, write domain
//   i_err_clr/o_pkt_err               : sticky forced-release flag and its clear
//   o_busy/o_grant_id                 : grant held / current or most recent grant
// Modport master is the arbiter side, slave is the surrounding logic.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2
);
  logic [NUM_REQ-1:0]             i_req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_data;
  logic [NUM_REQ-1:0]             i_req_last;
  logic [NUM_REQ-1:0]             o_req_ready;
  logic                           o_fifo_wen;
  logic [ID_WIDTH+DATA_WIDTH-1:0] o_fifo_wdata;
  logic                           i_fifo_wfull;
  logic                           i_err_clr;
  logic                           o_busy;
  logic [ID_WIDTH-1:0]            o_grant_id;
  logic                           o_pkt_err;

  modport master (
    input  i_req_valid, i_req_data, i_req_last, i_fifo_wfull, i_err_clr,
    output o_req_ready, o_fifo_wen, o_fifo_wdata, o_busy, o_grant_id, o_pkt_err
  );

  modport slave (
    output i_req_valid, i_req_data, i_req_last, i_fifo_wfull, i_err_clr,
    input  o_req_ready, o_fifo_wen, o_fifo_wdata, o_busy, o_grant_id, o_pkt_err
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotating-priority one-of-N selector.
//   req        : request vector
//   last_grant : most recent winner; search starts at last_grant+1 (mod NUM_REQ)
//   grant      : index of the first requesting slot in that order (0 if none)
//   any_req    : at least one request is set
module fifo_wr_arbiter_rr_pick #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] last_grant,
  output logic [ID_WIDTH-1:0] grant,
  output logic                any_req
);

  int idx;

  assign any_req = |req;

  // Walk the rotation from the farthest slot back to the nearest one, so the
  // closest requester after last_grant is the value left standing.
  always_comb begin
    grant = '0;
    idx   = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (req[idx]) begin
        grant = ID_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one FIFO write port among
// NUM_REQ valid/ready/last streams. A winner keeps the port until its last
// beat is written or MAX_PKT beats have gone through, and every FIFO word
// carries the source tag in its top ID_WIDTH bits.
//   i_wclk   : write-domain clock
//   i_wrst_n : asynchronous active-low reset
//   bus      : requester streams, FIFO write port and status (fifo_wr_arbiter_if)
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2,
  parameter int MAX_PKT    = 16
) (
  input  logic               i_wclk,
  input  logic               i_wrst_n,
  fifo_wr_arbiter_if.master  bus
);

  localparam int                    CNT_WIDTH = clog2(MAX_PKT + 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(MAX_PKT - 1);
  localparam logic [ID_WIDTH-1:0]   LAST_INIT = ID_WIDTH'(NUM_REQ - 1);

  state_t                 state_reg, state_next;
  logic [ID_WIDTH-1:0]    grant_reg, grant_next;
  logic [ID_WIDTH-1:0]    last_grant_reg, last_grant_next;
  logic [CNT_WIDTH-1:0]   beat_cnt_reg, beat_cnt_next;
  logic                   pkt_err_reg, pkt_err_next;

  logic [ID_WIDTH-1:0]    pick_id;
  logic                   any_req;
  logic [NUM_REQ-1:0]     ready;
  logic                   wr_en;
  logic [ID_WIDTH+DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0]  payload [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign payload[gi] = bus.i_req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  fifo_wr_arbiter_rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req        (bus.i_req_valid),
    .last_grant (last_grant_reg),
    .grant      (pick_id),
    .any_req    (any_req)
  );

  always_ff @(posedge i_wclk or negedge i_wrst_n) begin
    if (!i_wrst_n) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= LAST_INIT;
      beat_cnt_reg   <= '0;
      pkt_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      beat_cnt_reg   <= beat_cnt_next;
      pkt_err_reg    <= pkt_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    beat_cnt_next   = beat_cnt_reg;
    // A forced release below overrides the clear in the same cycle.
    pkt_err_next    = pkt_err_reg & ~bus.i_err_clr;
    ready           = '0;
    wr_en           = 1'b0;
    wr_data         = '0;

    case (state_reg)
      IDLE: begin
        if (any_req) begin
          grant_next = pick_id;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // Full gates ready and the write in the same cycle, so a stalled beat
        // is simply offered again and the counter does not move.
        ready[grant_reg] = ~bus.i_fifo_wfull;
        wr_en            = bus.i_req_valid[grant_reg] & ~bus.i_fifo_wfull;
        if (wr_en) begin
          wr_data = {grant_reg, payload[grant_reg]};
          if (bus.i_req_last[grant_reg] || (beat_cnt_reg == CNT_LAST)) begin
            state_next      = IDLE;
            last_grant_next = grant_reg;
            beat_cnt_next   = '0;
            if (!bus.i_req_last[grant_reg]) begin
              pkt_err_next = 1'b1;
            end
          end else begin
            beat_cnt_next = beat_cnt_reg + CNT_WIDTH'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.o_req_ready  = ready;
  assign bus.o_fifo_wen   = wr_en;
  assign bus.o_fifo_wdata = wr_data;
  assign bus.o_busy       = (state_reg == BUSY);
  assign bus.o_grant_id   = grant_reg;
  assign bus.o_pkt_err    = pkt_err_reg;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_PKT=16).
// Requesters are modelled as beat queues; each cycle the front beat of every
// active queue is presented and popped when valid & ready. Writes seen on the
// FIFO port are logged and compared with directed expectations or with a
// packet-level round-robin model.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
  import fifo_wr_arbiter_pkg::*;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int ID_WIDTH   = 2;
  localparam int MAX_PKT    = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH), .MAX_PKT(MAX_PKT)
  ) dut (
    .i_wclk   (clk),
    .i_wrst_n (rst_n),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // requester beat storage: {last, data}
  logic [8:0] mem [4][64];
  int head [4];
  int tail [4];
  int start_cyc [4];
  logic full_pat [512];
  bit rand_full;
  int tcyc;
  int wr_tag [$];
  int wr_data [$];
  int wr_cyc [$];

  // outputs/inputs sampled at the falling edge of cycle s_cyc
  logic       s_wen, s_busy, s_full, s_err;
  logic [9:0] s_wdata;
  logic [3:0] s_ready, s_valid;
  logic [1:0] s_grant;
  int         s_cyc;

  task automatic clear_stim();
    for (int k = 0; k < 4; k++) begin
      head[k] = 0; tail[k] = 0; start_cyc[k] = 0;
    end
    for (int c = 0; c < 512; c++) full_pat[c] = 1'b0;
    rand_full = 1'b0;
    tcyc = 0;
    wr_tag.delete(); wr_data.delete(); wr_cyc.delete();
  endtask

  task automatic push_beat(input int k, input int d, input bit last);
    mem[k][tail[k]] = {last, 8'(d)};
    tail[k]++;
  endtask

  task automatic drive_inputs();
    logic [3:0]  v, l;
    logic [31:0] d;
    v = '0; l = '0; d = '0;
    for (int k = 0; k < 4; k++) begin
      if (head[k] < tail[k] && tcyc >= start_cyc[k]) begin
        v[k] = 1'b1;
        d[k*8 +: 8] = mem[k][head[k]][7:0];
        l[k] = mem[k][head[k]][8];
      end
    end
    bus.i_req_valid = v;
    bus.i_req_data  = d;
    bus.i_req_last  = l;
    bus.i_fifo_wfull = rand_full ? ($urandom_range(0, 99) < 30)
                                 : ((tcyc < 512) ? full_pat[tcyc] : 1'b0);
  endtask

  task automatic run_cycle();
    @(negedge clk);
    s_cyc = tcyc;
    s_wen = bus.o_fifo_wen; s_wdata = bus.o_fifo_wdata; s_ready = bus.o_req_ready;
    s_busy = bus.o_busy; s_grant = bus.o_grant_id; s_err = bus.o_pkt_err;
    s_full = bus.i_fifo_wfull; s_valid = bus.i_req_valid;
    if (s_wen) begin
      wr_tag.push_back(int'(s_wdata[9:8]));
      wr_data.push_back(int'(s_wdata[7:0]));
      wr_cyc.push_back(tcyc);
    end
    for (int k = 0; k < 4; k++) begin
      if (s_valid[k] && s_ready[k]) head[k]++;
    end
    @(posedge clk);
    #1;
    tcyc++;
    drive_inputs();
  endtask

  task automatic run_until(input int nwr, input int budget, output bit timed_out);
    int n;
    n = 0;
    while (wr_tag.size() < nwr && n < budget) begin
      run_cycle();
      n++;
    end
    timed_out = (wr_tag.size() < nwr);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_req_valid = '0; bus.i_req_data = '0; bus.i_req_last = '0;
    bus.i_fifo_wfull = 1'b0; bus.i_err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_req_valid = 4'hF; bus.i_req_data = 32'hFFFF_FFFF; bus.i_req_last = 4'hF;
    bus.i_fifo_wfull = 1'b0; bus.i_err_clr = 1'b0;
    #3;
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", bus.o_busy); end
    n_cmp++; if (bus.o_fifo_wen !== 1'b0) begin n_bad++; $display("FAIL rst_wen: got %b expected 0", bus.o_fifo_wen); end
    n_cmp++; if (bus.o_fifo_wdata !== 10'h0) begin n_bad++; $display("FAIL rst_wdata: got %h expected 000", bus.o_fifo_wdata); end
    n_cmp++; if (bus.o_req_ready !== 4'h0) begin n_bad++; $display("FAIL rst_ready: got %b expected 0000", bus.o_req_ready); end
    n_cmp++; if (bus.o_grant_id !== 2'd0) begin n_bad++; $display("FAIL rst_grant: got %0d expected 0", bus.o_grant_id); end
    n_cmp++; if (bus.o_pkt_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b expected 0", bus.o_pkt_err); end
    $display("reset: outputs checked while reset held");
    do_reset();
    @(negedge clk);
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL rst_idle_busy: got %b expected 0", bus.o_busy); end
  endtask

  task automatic test_simultaneous();
    bit to;
    int got, gc;
    int exp_wd [4] = '{32'h0A0, 32'h1A1, 32'h2A2, 32'h3A3};
    do_reset(); clear_stim();
    for (int k = 0; k < 4; k++) push_beat(k, 8'hA0 + k, 1'b1);
    drive_inputs();
    run_until(4, 40, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL sim_timeout: got %0d writes expected 4", wr_tag.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < wr_tag.size()) ? wr_tag[i] * 256 + wr_data[i] : -1;
      gc  = (i < wr_cyc.size()) ? wr_cyc[i] : -1;
      $display("simultaneous: write %0d wdata=%h cycle=%0d", i, got, gc);
      n_cmp++; if (got !== exp_wd[i]) begin n_bad++; $display("FAIL sim_wdata%0d: got %h expected %h", i, got, exp_wd[i]); end
      n_cmp++; if (gc !== 1 + 2 * i) begin n_bad++; $display("FAIL sim_cycle%0d: got %0d expected %0d", i, gc, 1 + 2 * i); end
    end
  endtask

  task automatic test_packet_lock();
    bit to;
    int got, gc;
    int exp_wd [4] = '{32'h10B, 32'h10C, 32'h10D, 32'h222};
    int exp_c [4]  = '{1, 2, 3, 5};
    do_reset(); clear_stim();
    push_beat(1, 11, 1'b0); push_beat(1, 12, 1'b0); push_beat(1, 13, 1'b1);
    push_beat(2, 8'h22, 1'b1);
    drive_inputs();
    run_until(4, 40, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL lock_timeout: got %0d writes expected 4", wr_tag.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < wr_tag.size()) ? wr_tag[i] * 256 + wr_data[i] : -1;
      gc  = (i < wr_cyc.size()) ? wr_cyc[i] : -1;
      $display("packet_lock: write %0d wdata=%h cycle=%0d", i, got, gc);
      n_cmp++; if (got !== exp_wd[i]) begin n_bad++; $display("FAIL lock_wdata%0d: got %h expected %h", i, got, exp_wd[i]); end
      n_cmp++; if (gc !== exp_c[i]) begin n_bad++; $display("FAIL lock_cycle%0d: got %0d expected %0d", i, gc, exp_c[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int got, gc, guard;
    int exp_c [4] = '{1, 2, 8, 9};
    do_reset(); clear_stim();
    for (int b = 0; b < 4; b++) push_beat(0, 8'h40 + b, b == 3);
    for (int c = 3; c <= 7; c++) full_pat[c] = 1'b1;
    drive_inputs();
    guard = 0;
    while (wr_tag.size() < 4 && guard < 40) begin
      run_cycle();
      guard++;
      if (s_cyc >= 3 && s_cyc <= 7) begin
        $display("backpressure: cycle %0d full wen=%b ready=%b busy=%b", s_cyc, s_wen, s_ready, s_busy);
        n_cmp++; if (s_wen !== 1'b0) begin n_bad++; $display("FAIL bp_wen_c%0d: got %b expected 0", s_cyc, s_wen); end
        n_cmp++; if (s_ready[0] !== 1'b0) begin n_bad++; $display("FAIL bp_ready_c%0d: got %b expected 0", s_cyc, s_ready[0]); end
        n_cmp++; if (s_busy !== 1'b1) begin n_bad++; $display("FAIL bp_busy_c%0d: got %b expected 1", s_cyc, s_busy); end
      end
    end
    repeat (5) run_cycle();
    n_cmp++; if (wr_tag.size() !== 4) begin n_bad++; $display("FAIL bp_count: got %0d writes expected 4", wr_tag.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < wr_tag.size()) ? wr_tag[i] * 256 + wr_data[i] : -1;
      gc  = (i < wr_cyc.size()) ? wr_cyc[i] : -1;
      n_cmp++; if (got !== 32'h040 + i) begin n_bad++; $display("FAIL bp_wdata%0d: got %h expected %h", i, got, 32'h040 + i); end
      n_cmp++; if (gc !== exp_c[i]) begin n_bad++; $display("FAIL bp_cycle%0d: got %0d expected %0d", i, gc, exp_c[i]); end
    end
  endtask

  task automatic test_watchdog();
    int got, guard, ew;
    int ec [3] = '{16, 18, 20};
    do_reset(); clear_stim();
    // 20 beats; only beat 20 carries last, so the first 16 hit the limit
    for (int b = 0; b < 20; b++) push_beat(3, 8'h30 + b, b == 19);
    push_beat(0, 8'h0F, 1'b1);
    start_cyc[0] = 5;
    drive_inputs();
    guard = 0;
    while (wr_tag.size() < 21 && guard < 100) begin
      run_cycle();
      guard++;
      if (s_cyc == 16) begin
        n_cmp++; if (s_err !== 1'b0) begin n_bad++; $display("FAIL wd_err_early: got %b expected 0", s_err); end
      end
      if (s_cyc == 17) begin
        n_cmp++; if (s_err !== 1'b1) begin n_bad++; $display("FAIL wd_err_set: got %b expected 1", s_err); end
      end
    end
    n_cmp++; if (wr_tag.size() !== 21) begin n_bad++; $display("FAIL wd_count: got %0d writes expected 21", wr_tag.size()); end
    for (int i = 0; i < 21; i++) begin
      if (i < 16) ew = 3 * 256 + 8'h30 + i;
      else if (i == 16) ew = 32'h00F;
      else ew = 3 * 256 + 8'h30 + i - 1;
      got = (i < wr_tag.size()) ? wr_tag[i] * 256 + wr_data[i] : -1;
      n_cmp++; if (got !== ew) begin n_bad++; $display("FAIL wd_wdata%0d: got %h expected %h", i, got, ew); end
    end
    for (int i = 0; i < 3; i++) begin
      got = (15 + i < wr_cyc.size()) ? wr_cyc[15 + i] : -1;
      $display("watchdog: write %0d at cycle %0d", 15 + i, got);
      n_cmp++; if (got !== ec[i]) begin n_bad++; $display("FAIL wd_cycle%0d: got %0d expected %0d", 15 + i, got, ec[i]); end
    end
    n_cmp++; if (bus.o_pkt_err !== 1'b1) begin n_bad++; $display("FAIL wd_err_sticky: got %b expected 1", bus.o_pkt_err); end
    bus.i_err_clr = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.o_pkt_err !== 1'b1) begin n_bad++; $display("FAIL wd_err_preclr: got %b expected 1", bus.o_pkt_err); end
    @(posedge clk);
    #1 bus.i_err_clr = 1'b0;
    #1;
    n_cmp++; if (bus.o_pkt_err !== 1'b0) begin n_bad++; $display("FAIL wd_err_clr: got %b expected 0", bus.o_pkt_err); end
  endtask

  task automatic test_reset_mid();
    bit to;
    int got;
    do_reset(); clear_stim();
    for (int b = 0; b < 4; b++) push_beat(2, 8'h50 + b, b == 3);
    drive_inputs();
    run_cycle(); run_cycle();
    #1;
    n_cmp++; if (bus.o_fifo_wen !== 1'b1 || bus.o_grant_id !== 2'd2) begin
      n_bad++; $display("FAIL rm_pre: got wen=%b grant=%0d expected wen=1 grant=2", bus.o_fifo_wen, bus.o_grant_id);
    end
    #1 rst_n = 1'b0;
    #1;
    $display("reset_mid: busy=%b wen=%b grant=%0d", bus.o_busy, bus.o_fifo_wen, bus.o_grant_id);
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL rm_busy: got %b expected 0", bus.o_busy); end
    n_cmp++; if (bus.o_fifo_wen !== 1'b0) begin n_bad++; $display("FAIL rm_wen: got %b expected 0", bus.o_fifo_wen); end
    n_cmp++; if (bus.o_grant_id !== 2'd0) begin n_bad++; $display("FAIL rm_grant: got %0d expected 0", bus.o_grant_id); end
    repeat (2) @(posedge clk);
    clear_stim();
    for (int k = 0; k < 4; k++) push_beat(k, 8'hC0 + k, 1'b1);
    #1 rst_n = 1'b1;
    drive_inputs();
    run_until(4, 40, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL rm_timeout: got %0d writes expected 4", wr_tag.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < wr_tag.size()) ? wr_tag[i] : -1;
      n_cmp++; if (got !== i) begin n_bad++; $display("FAIL rm_order%0d: got %0d expected %0d", i, got, i); end
    end
  endtask

  task automatic test_starvation();
    bit to;
    int got, gc;
    do_reset(); clear_stim();
    for (int p = 0; p < 5; p++) begin
      push_beat(0, 8'h60 + 2 * p, 1'b0);
      push_beat(0, 8'h61 + 2 * p, 1'b1);
    end
    push_beat(3, 8'h7F, 1'b1);
    start_cyc[3] = 2;
    drive_inputs();
    run_until(11, 80, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL starve_timeout: got %0d writes expected 11", wr_tag.size()); end
    got = (wr_tag.size() > 2) ? wr_tag[2] * 256 + wr_data[2] : -1;
    gc  = (wr_cyc.size() > 2) ? wr_cyc[2] : -1;
    $display("starvation: third write wdata=%h cycle=%0d", got, gc);
    n_cmp++; if (got !== 32'h37F) begin n_bad++; $display("FAIL starve_wdata: got %h expected 37f", got); end
    n_cmp++; if (gc !== 4) begin n_bad++; $display("FAIL starve_cycle: got %0d expected 4", gc); end
  endtask

  task automatic test_random(input int round);
    int exp_tag [$];
    int exp_data [$];
    bit exp_err;
    int mh [4];
    int lastg, pick, nb, len, guard, got, kk;
    logic [8:0] beat;
    logic [3:0] exp_ready;
    do_reset(); clear_stim();
    rand_full = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 3; p++) begin
        len = $urandom_range(1, 20);
        for (int b = 0; b < len; b++) push_beat(k, $urandom_range(0, 255), b == len - 1);
      end
    end
    // packet-level model: grants rotate over requesters with beats pending;
    // each grant runs to its last beat or MAX_PKT beats, whichever is first
    exp_err = 1'b0;
    lastg = NUM_REQ - 1;
    for (int k = 0; k < 4; k++) mh[k] = 0;
    pick = 0;
    while (pick >= 0) begin
      pick = -1;
      for (int s = NUM_REQ; s >= 1; s--) begin
        kk = (lastg + s) % NUM_REQ;
        if (mh[kk] < tail[kk]) pick = kk;
      end
      if (pick >= 0) begin
        nb = 0;
        while (mh[pick] < tail[pick]) begin
          beat = mem[pick][mh[pick]];
          mh[pick]++;
          nb++;
          exp_tag.push_back(pick);
          exp_data.push_back(int'(beat[7:0]));
          if (beat[8]) break;
          if (nb == MAX_PKT) begin
            exp_err = 1'b1;
            break;
          end
        end
        lastg = pick;
      end
    end
    drive_inputs();
    guard = 0;
    while (wr_tag.size() < exp_tag.size() && guard < 3000) begin
      run_cycle();
      guard++;
      n_cmp++; if (!s_wen && s_wdata !== 10'h0) begin n_bad++; $display("FAIL rnd%0d_wdata_idle c%0d: got %h expected 000", round, s_cyc, s_wdata); end
      exp_ready = (s_busy && !s_full) ? (4'b0001 << s_grant) : 4'b0000;
      n_cmp++; if (s_ready !== exp_ready) begin n_bad++; $display("FAIL rnd%0d_ready c%0d: got %b expected %b", round, s_cyc, s_ready, exp_ready); end
    end
    $display("random%0d: %0d writes expected, %0d seen, %0d cycles", round, exp_tag.size(), wr_tag.size(), guard);
    n_cmp++; if (wr_tag.size() !== exp_tag.size()) begin n_bad++; $display("FAIL rnd%0d_count: got %0d expected %0d", round, wr_tag.size(), exp_tag.size()); end
    for (int i = 0; i < exp_tag.size(); i++) begin
      got = (i < wr_tag.size()) ? wr_tag[i] * 256 + wr_data[i] : -1;
      n_cmp++; if (got !== exp_tag[i] * 256 + exp_data[i]) begin
        n_bad++; $display("FAIL rnd%0d_word%0d: got %h expected %h", round, i, got, exp_tag[i] * 256 + exp_data[i]);
      end
    end
    n_cmp++; if (bus.o_pkt_err !== exp_err) begin n_bad++; $display("FAIL rnd%0d_err: got %b expected %b", round, bus.o_pkt_err, exp_err); end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_packet_lock();
    test_backpressure();
    test_watchdog();
    test_reset_mid();
    test_starvation();
    for (int r = 0; r < 3; r++) test_random(r);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2 ms");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares one async FIFO write port (write-clock side) among N requesters.
- Each requester presents a valid/ready/last stream; the winner keeps the port until its last beat is accepted, or until a watchdog limit is hit.
- Each beat is tagged with the source ID, so the read side can demultiplex.
- Sits entirely in the FIFO write clock domain, directly ahead of the FIFO write port.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, payload width per requester.
- ID_WIDTH, 2, tag width; must equal ceil(log2(NUM_REQ)), minimum 1.
- MAX_PKT, 16, maximum beats per grant before forced release (>=1).

Ports:
- i_wclk, in, 1, write-domain clock.
- i_wrst_n, in, 1, reset, asynchronous, active-low.
- i_req_valid, in, NUM_REQ, per-requester beat valid.
- i_req_data, in, NUM_REQ*DATA_WIDTH, requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_req_last, in, NUM_REQ, last beat of packet, qualified by valid.
- o_req_ready, out, NUM_REQ, beat accepted when valid & ready.
- o_fifo_wen, out, 1, FIFO write enable.
- o_fifo_wdata, out, ID_WIDTH+DATA_WIDTH, {grant_id, payload}.
- i_fifo_wfull, in, 1, FIFO full flag, write domain.
- i_err_clr, in, 1, clears o_pkt_err.
- o_busy, out, 1, a grant is held.
- o_grant_id, out, ID_WIDTH, current or most recent grant.
- o_pkt_err, out, 1, sticky: a packet was force-released at MAX_PKT.

Behaviour:
- Reset values:
  - state = IDLE.
  - last_grant = NUM_REQ-1, so requester 0 has first priority.
  - o_grant_id = 0.
  - beat_cnt = 0.
  - o_pkt_err = 0.
  - All ready, wen and busy outputs = 0.
  - o_fifo_wdata = 0 while wen is 0.
- FSM states: IDLE and BUSY.
- IDLE:
  - If any i_req_valid is set, select the first valid requester searching from last_grant+1 (mod NUM_REQ) upward.
  - Register it into o_grant_id and go to BUSY on the next edge.
  - No beat is accepted in IDLE, so o_req_ready = 0.
- BUSY, with g = o_grant_id:
  - o_req_ready[g] = ~i_fifo_wfull; all other ready bits are 0.
  - o_fifo_wen = i_req_valid[g] & ~i_fifo_wfull.
  - o_fifo_wdata = {g, payload of requester g}; purely combinational, zero added latency.
- Accepted beat means o_fifo_wen = 1. On each accepted beat:
  - If i_req_last[g]: go to IDLE, set last_grant <= g, clear beat_cnt.
  - Else if beat_cnt == MAX_PKT-1: force release, exactly as for a last beat, and set o_pkt_err.
  - Else: beat_cnt <= beat_cnt + 1.
  - beat_cnt width is ceil(log2(MAX_PKT+1)).
- Valid dropping mid-packet: the grant is held, BUSY persists, nothing is written. There is no timeout on idle valid.
- FIFO full: ready and wen are both 0, beat_cnt is frozen and the grant is held. Full is checked combinationally every cycle, so no beat is lost or duplicated.
- Inter-packet gap: at least 1 cycle (the IDLE arbitration cycle). Peak throughput is L/(L+1) for L-beat packets.
- Single-beat packet (valid & last on the first BUSY cycle): one write, then back to IDLE.
- Fairness: in steady state, requesters with continuous valid are served in ascending cyclic order. A requester waits at most NUM_REQ-1 grants.
- o_busy = (state == BUSY).
- o_grant_id holds its value in IDLE until the next grant.
- o_pkt_err:
  - Set has priority over i_err_clr in the same cycle.
  - Otherwise i_err_clr clears it.
- Reset asserted mid-packet: outputs go to reset values immediately and asynchronously. The partial packet stays in the FIFO; the FIFO owner is responsible for resetting the FIFO alongside.
- Requester obligations:
  - Data, last and valid stay stable until the beat is accepted.
  - The arbiter does not check this; stability is an SVA obligation on requesters.

Decomposition:
- Shared package holds:
  - state encoding localparams (ST_IDLE = 1'b0, ST_BUSY = 1'b1);
  - a clog2 function;
  - the tag-width rule.
- One natural sub-module: rr_pick.
  - Combinational rotating-priority one-of-N selector.
  - Inputs: request vector, last_grant. Outputs: grant index, any_req.
  - Reusable by the read-side scheduler.

Test Plan:
All cases use NUM_REQ=4, DATA_WIDTH=8, MAX_PKT=16.
- Simultaneous requests: requesters 0..3 each send one 1-beat packet (data 8'hA0..8'hA3) together after reset -> FIFO receives tags 0,1,2,3 in order, wdata 10'h0A0, 10'h1A1, 10'h2A2, 10'h3A3, with one idle cycle between writes.
- Packet lock: req1 sends 3 beats (11,12,13, last on 13) while req2 is valid throughout -> the three req1 beats are contiguous, and req2's first beat appears only after an IDLE cycle.
- Backpressure: i_fifo_wfull high for 5 cycles in the middle of req0's 4-beat packet -> o_fifo_wen = 0 and o_req_ready[0] = 0 during those cycles, beat_cnt holds, and exactly 4 writes complete after full drops.
- Watchdog: req3 sends 20 beats with no last -> forced release after beat 16, o_pkt_err = 1 and stays set, the next grant goes to the next valid requester; a pulse on i_err_clr clears it.
- Reset mid-packet: assert i_wrst_n low during beat 2 of req2 -> same-cycle o_busy = 0, o_fifo_wen = 0, o_grant_id = 0; after release, the first grant with all requesters valid goes to req0.
- Starvation bound: req0 is continuously valid with 2-beat packets while req3 makes a single request -> req3 is granted within the next grant cycle after req0's current packet.
